hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard and stall controller; the stall/flush side of EX-stage operand bypassing.
//  - Detects load-use hazards that bypassing cannot cover and inserts one bubble.
//  - Flushes wrong-path instructions on a taken branch.
//  - Freezes the whole pipeline while data memory is busy.
//  - Stops the machine permanently once a HALT retires in WB.
//  - Drives the write enables and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// PARAMETERS
//  REG_W       4     register-specifier width
//  WAIT_LIMIT  255   consecutive mem_busy cycles before wait_err sets (1..2^16-1)
//  CNT_W       16    width of performance counters
// PORTS
//  clk             in   1      clock, rising edge
//  rst_n           in   1      reset, asynchronous, active-low
//  if_id_regrs     in   REG_W  source reg 1 of instruction in ID
//  if_id_regrt     in   REG_W  source reg 2 of instruction in ID
//  if_id_use_rs    in   1      ID instruction reads rs
//  if_id_use_rt    in   1      ID instruction reads rt
//  id_ex_memread   in   1      instruction in EX is a load
//  id_ex_regdest   in   REG_W  destination reg of instruction in EX
//  ex_branch_taken in   1      branch/jump in EX resolved taken
//  mem_busy        in   1      data memory cannot complete this cycle
//  wb_halt         in   1      HALT instruction is in WB
//  pc_write        out  1      PC update enable
//  if_id_write     out  1      IF/ID load enable
//  if_id_flush     out  1      IF/ID loads a NOP
//  id_ex_write     out  1      ID/EX load enable
//  id_ex_bubble    out  1      ID/EX loads a NOP (control zeroed)
//  ex_mem_write    out  1      EX/MEM load enable
//  mem_wb_write    out  1      MEM/WB load enable
//  halted          out  1      registered; machine stopped
//  wait_err        out  1      registered, sticky; memory wait exceeded WAIT_LIMIT
//  stall_cycles    out  CNT_W  perf: cycles lost to stalls/freezes
//  flush_count     out  CNT_W  perf: taken-branch flushes
// BEHAVIOUR
//  Reset (rst_n=0)
//   - state=RUN; wait_cnt=0; halted=0; wait_err=0; counters=0.
//   - All *_write, if_id_flush and id_ex_bubble are forced 0.
//  Outputs
//   - Mealy: decoded from registered state plus current inputs; zero-cycle latency.
//   - Default (no event): all *_write=1, flush/bubble=0.
//  load_use = id_ex_memread & (id_ex_regdest!=0)
//             & ((if_id_use_rs & regdest==regrs) | (if_id_use_rt & regdest==regrt)).
//  States
//   RUN, priority high to low:
//    - wb_halt: all *_write=0; next state HALTED.
//    - mem_busy: all *_write=0 (full freeze); wait_cnt<=1; next state MEM_WAIT.
//    - ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1 (PC loads target).
//      Overrides load_use; the hazarding instruction is wrong-path.
//    - load_use: pc_write=0, if_id_write=0, id_ex_bubble=1; EX/MEM, MEM/WB advance.
//      Exactly one bubble per hazard; the load moves to MEM and is then bypassed.
//   MEM_WAIT:
//    - wb_halt: same as in RUN.
//    - mem_busy=1: full freeze; wait_cnt increments, saturating.
//      wait_err<=1 when wait_cnt reaches WAIT_LIMIT.
//    - mem_busy=0: decode as in RUN this same cycle; wait_cnt<=0; next state RUN.
//      A branch in EX stays frozen during MEM_WAIT and is flushed on release.
//   HALTED:
//    - All *_write=0, flush/bubble=0, halted=1.
//    - All inputs ignored; exit only via rst_n.
//  Boundary rules
//   - wait_err stays 1 until reset; it does not alter control outputs.
//   - Reset asserted mid-freeze or mid-stall: immediate return to reset values.
// CONFIGURATION
//  HAZARD_PERF_EN
//   - Defined:
//     - stall_cycles +1 on each load_use-stall or freeze cycle (excludes HALTED).
//     - flush_count +1 on each taken-branch flush.
//     - Both saturate at 2^CNT_W-1.
//   - Undefined: both outputs tied to 0; no counter flops.
// TESTING
//  T1 load-use: memread=1, regdest=3, regrs=3, use_rs=1
//     -> pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly 1 cycle; stall_cycles=1.
//  T2 regdest=0 with matching regrs=0, memread=1
//     -> no stall, all *_write=1.
//  T3 branch_taken=1 together with a load_use hit
//     -> if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1; flush_count=1.
//  T4 mem_busy high 3 cycles, branch in EX
//     -> all *_write=0 for 3 cycles, flush on 4th; stall_cycles=3.
//  T5 WAIT_LIMIT=4, mem_busy held 6 cycles
//     -> wait_err=1 after the 4th busy cycle; stays 1 after mem_busy falls.
//  T6 wb_halt=1 with mem_busy=1
//     -> all *_write=0; halted=1 next cycle; then stuck until rst_n pulse resets all.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes, memory freezes, halt.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
   parameter int unsigned REG_W      = 4,
   parameter int unsigned WAIT_LIMIT = 255,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] if_id_regrs,
   input  logic [REG_W-1:0] if_id_regrt,
   input  logic             if_id_use_rs,
   input  logic             if_id_use_rt,
   input  logic             id_ex_memread,
   input  logic [REG_W-1:0] id_ex_regdest,
   input  logic             ex_branch_taken,
   input  logic             mem_busy,
   input  logic             wb_halt,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_bubble,
   output logic             ex_mem_write,
   output logic             mem_wb_write,
   output logic             halted,
   output logic             wait_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {StRun, StMemWait, StHalted} state_e;

   localparam logic [15:0] WaitLimit = 16'(WAIT_LIMIT);

   state_e      state_q, state_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        wait_err_q, wait_err_d;
   logic        load_use;

   assign load_use = id_ex_memread && (id_ex_regdest != '0) &&
                     ((if_id_use_rs && (id_ex_regdest == if_id_regrs)) ||
                      (if_id_use_rt && (id_ex_regdest == if_id_regrt)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StRun;
         wait_cnt_q <= '0;
         wait_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         wait_err_q <= wait_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      wait_err_d = wait_err_q;
      case (state_q)
         StRun, StMemWait: begin
            if (wb_halt) begin
               state_d = StHalted;
            end else if (mem_busy) begin
               state_d = StMemWait;
               if (state_q == StRun) begin
                  wait_cnt_d = 16'd1;
               end else if (wait_cnt_q != 16'hFFFF) begin
                  wait_cnt_d = wait_cnt_q + 16'd1;
               end
               // Flags on the busy cycle whose count reaches the limit.
               if (wait_cnt_d >= WaitLimit) begin
                  wait_err_d = 1'b1;
               end
            end else begin
               state_d    = StRun;
               wait_cnt_d = '0;
            end
         end
         StHalted: state_d = StHalted;
         default:  state_d = StRun;
      endcase
   end

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      if (!rst_n || (state_q == StHalted) || wb_halt || mem_busy) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_write = 1'b0;
      end else if (ex_branch_taken) begin
         // The hazarding instruction is wrong-path, so the flush wins.
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (load_use) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

   assign halted   = (state_q == StHalted);
   assign wait_err = wait_err_q;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_q, flush_q;
   logic             stall_evt;

   // pc_write is low exactly on halt, freeze and load-use cycles; drop the halt ones.
   assign stall_evt = !pc_write && !wb_halt && (state_q != StHalted);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall_evt && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
         end
         if (if_id_flush && (flush_q != '1)) begin
            flush_q <= flush_q + 1'b1;
         end
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a scoreboard of expected per-cycle outputs.
module tb_hazard_ctrl;

   localparam int unsigned REG_W = 4;
   localparam int unsigned CNT_W = 16;
`ifdef HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [4:0] ALL  = 5'b11111;
   localparam logic [4:0] NONE = 5'b00000;
   localparam logic [4:0] LU   = 5'b00111;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [REG_W-1:0] if_id_regrs, if_id_regrt, id_ex_regdest;
   logic             if_id_use_rs, if_id_use_rt, id_ex_memread;
   logic             ex_branch_taken, mem_busy, wb_halt;
   logic             pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
   logic             ex_mem_write, mem_wb_write, halted, wait_err;
   logic [CNT_W-1:0] stall_cycles, flush_count;

   typedef struct packed {
      logic [4:0]  wr;
      logic        fl;
      logic        bub;
      logic        hlt;
      logic        werr;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   hazard_ctrl #(
      .REG_W      (REG_W),
      .WAIT_LIMIT (4),
      .CNT_W      (CNT_W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .if_id_regrs     (if_id_regrs),
      .if_id_regrt     (if_id_regrt),
      .if_id_use_rs    (if_id_use_rs),
      .if_id_use_rt    (if_id_use_rt),
      .id_ex_memread   (id_ex_memread),
      .id_ex_regdest   (id_ex_regdest),
      .ex_branch_taken (ex_branch_taken),
      .mem_busy        (mem_busy),
      .wb_halt         (wb_halt),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .if_id_flush     (if_id_flush),
      .id_ex_write     (id_ex_write),
      .id_ex_bubble    (id_ex_bubble),
      .ex_mem_write    (ex_mem_write),
      .mem_wb_write    (mem_wb_write),
      .halted          (halted),
      .wait_err        (wait_err),
      .stall_cycles    (stall_cycles),
      .flush_count     (flush_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input string what, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, queue the expectation, compare at the falling edge.
   task automatic step(input string tag, input logic mr, input logic [3:0] rd,
                       input logic [3:0] rs, input logic [3:0] rt, input logic urs,
                       input logic urt, input logic br, input logic busy, input logic hin,
                       input logic [4:0] wr, input logic fl, input logic bub,
                       input logic hlt, input logic werr, input int sc, input int fc);
      exp_t e;
      logic [4:0] obs_wr;
      id_ex_memread   = mr;
      id_ex_regdest   = rd;
      if_id_regrs     = rs;
      if_id_regrt     = rt;
      if_id_use_rs    = urs;
      if_id_use_rt    = urt;
      ex_branch_taken = br;
      mem_busy        = busy;
      wb_halt         = hin;
      e.wr   = wr;
      e.fl   = fl;
      e.bub  = bub;
      e.hlt  = hlt;
      e.werr = werr;
      e.sc   = PERF ? 16'(sc) : 16'd0;
      e.fc   = PERF ? 16'(fc) : 16'd0;
      sb_q.push_back(e);
      @(negedge clk);
      e = sb_q.pop_front();
      obs_wr = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write};
      chk(tag, "writes", 32'(obs_wr), 32'(e.wr));
      chk(tag, "if_id_flush", 32'(if_id_flush), 32'(e.fl));
      chk(tag, "id_ex_bubble", 32'(id_ex_bubble), 32'(e.bub));
      chk(tag, "halted", 32'(halted), 32'(e.hlt));
      chk(tag, "wait_err", 32'(wait_err), 32'(e.werr));
      chk(tag, "stall_cycles", 32'(stall_cycles), 32'(e.sc));
      chk(tag, "flush_count", 32'(flush_count), 32'(e.fc));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      #1;
      // Reset forces controls low even with a taken branch present.
      step("reset", 0, 0, 0, 0, 0, 0, 1, 0, 0, NONE, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, 0, 0, 0, 0, 0, 0);
      // T1: load-use on rs, then one bubble only
      step("t1_lu_rs", 1, 3, 3, 0, 1, 0, 0, 0, 0, LU, 0, 1, 0, 0, 0, 0);
      step("t1_after", 0, 0, 3, 0, 1, 0, 0, 0, 0, ALL, 0, 0, 0, 0, 1, 0);
      step("lu_unused", 1, 5, 5, 2, 0, 1, 0, 0, 0, ALL, 0, 0, 0, 0, 1, 0);
      step("lu_rt", 1, 6, 1, 6, 0, 1, 0, 0, 0, LU, 0, 1, 0, 0, 1, 0);
      // T2: r0 destination never stalls
      step("t2_r0", 1, 0, 0, 0, 1, 1, 0, 0, 0, ALL, 0, 0, 0, 0, 2, 0);
      step("not_load", 0, 3, 3, 3, 1, 1, 0, 0, 0, ALL, 0, 0, 0, 0, 2, 0);
      // T3: taken branch overrides load-use
      step("t3_br_lu", 1, 3, 3, 0, 1, 0, 1, 0, 0, ALL, 1, 1, 0, 0, 2, 0);
      step("t3_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, 0, 0, 0, 0, 2, 1);
      // T4: three busy cycles with a branch in EX, flush on release
      step("t4_busy1", 0, 0, 0, 0, 0, 0, 1, 1, 0, NONE, 0, 0, 0, 0, 2, 1);
      step("t4_busy2", 0, 0, 0, 0, 0, 0, 1, 1, 0, NONE, 0, 0, 0, 0, 3, 1);
      step("t4_busy3", 0, 0, 0, 0, 0, 0, 1, 1, 0, NONE, 0, 0, 0, 0, 4, 1);
      step("t4_release", 0, 0, 0, 0, 0, 0, 1, 0, 0, ALL, 1, 1, 0, 0, 5, 1);
      step("t4_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, 0, 0, 0, 0, 5, 2);
      // T5: six busy cycles, wait_err after the fourth
      step("t5_busy1", 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, 0, 0, 0, 0, 5, 2);
      step("t5_busy2", 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, 0, 0, 0, 0, 6, 2);
      step("t5_busy3", 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, 0, 0, 0, 0, 7, 2);
      step("t5_busy4", 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, 0, 0, 0, 0, 8, 2);
      step("t5_busy5", 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, 0, 0, 0, 1, 9, 2);
      step("t5_busy6", 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, 0, 0, 0, 1, 10, 2);
      step("t5_release", 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, 0, 0, 0, 1, 11, 2);
      step("t5_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, 0, 0, 0, 1, 11, 2);
      // Load-use decoded on the same cycle the memory releases
      step("mw_busy", 1, 4, 4, 0, 1, 0, 0, 1, 0, NONE, 0, 0, 0, 1, 11, 2);
      step("mw_rel_lu", 1, 4, 4, 0, 1, 0, 0, 0, 0, LU, 0, 1, 0, 1, 12, 2);
      step("mw_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, 0, 0, 0, 1, 13, 2);
      // T6: halt beats busy, then the machine ignores everything
      step("t6_halt", 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE, 0, 0, 0, 1, 13, 2);
      step("t6_halted", 0, 0, 0, 0, 0, 0, 1, 0, 0, NONE, 0, 0, 1, 1, 13, 2);
      step("t6_stuck", 1, 2, 2, 0, 1, 0, 0, 0, 0, NONE, 0, 0, 1, 1, 13, 2);
      rst_n = 1'b0;
      step("t6_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      step("t6_resume", 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, 0, 0, 0, 0, 0, 0);
      // Reset asserted in the middle of a freeze
      step("fz_busy", 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      step("fz_reset", 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      step("fz_resume", 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, 0, 0, 0, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
